// File: rtl/regfile_bypass_pkg.sv
// Shared processor constants for the architectural register file.
package regfile_bypass_pkg;

    localparam int RF_WIDTH      = 32;
    localparam int RF_DEPTH      = 32;
    localparam int RF_STATUS_IDX = 30;
    localparam int RF_ZERO_IDX   = 0;

endpackage

// File: rtl/regfile_bypass_reg_word.sv
// One register-file word: load on enable, synchronous clear wins over load.
module reg_word
    import regfile_bypass_pkg::*;
#(
    parameter int WIDTH = RF_WIDTH
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (clr) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/regfile_bypass.sv
// Architectural register file: two combinational read ports, one general write
// port, a status write port to a fixed index, and optional write-to-read bypass.
module regfile_bypass
    import regfile_bypass_pkg::*;
#(
    parameter int   WIDTH      = RF_WIDTH,
    parameter int   DEPTH      = RF_DEPTH,
    parameter int   STATUS_IDX = RF_STATUS_IDX,
    parameter bit   BYPASS     = 1'b1,
    localparam int  AW         = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             st_we,
    input  logic [WIDTH-1:0] st_data,
    input  logic [AW-1:0]    raddr_a,
    output logic [WIDTH-1:0] rdata_a,
    input  logic [AW-1:0]    raddr_b,
    output logic [WIDTH-1:0] rdata_b
);

    // Every encodable address gets a slot; slot 0 and slots >= DEPTH read as zero,
    // which makes the out-of-range read rule fall out of a plain array index.
    localparam int              SLOTS    = 2 ** AW;
    localparam logic [AW:0]     DEPTH_W  = (AW + 1)'(DEPTH);
    localparam logic [AW-1:0]   STATUS_A = AW'(STATUS_IDX);
    localparam logic [AW-1:0]   ZERO_A   = AW'(RF_ZERO_IDX);

    logic             wr_ok;
    logic             fwd_en;
    logic [WIDTH-1:0] word_q [SLOTS];

    assign wr_ok  = we && (waddr != ZERO_A) && ({1'b0, waddr} < DEPTH_W);
    assign fwd_en = BYPASS && !clr;

    for (genvar i = 0; i < SLOTS; i++) begin : g_word
        if (i == RF_ZERO_IDX || i >= DEPTH) begin : g_tied
            assign word_q[i] = '0;
        end else begin : g_store
            logic             en;
            logic [WIDTH-1:0] d;

            if (i == STATUS_IDX) begin : g_status
                // Status port wins a collision on its own index.
                assign en = st_we || (wr_ok && (waddr == AW'(i)));
                assign d  = st_we ? st_data : wdata;
            end else begin : g_plain
                assign en = wr_ok && (waddr == AW'(i));
                assign d  = wdata;
            end

            reg_word #(
                .WIDTH (WIDTH)
            ) u_word (
                .clk (clk),
                .clr (clr),
                .en  (en),
                .d   (d),
                .q   (word_q[i])
            );
        end
    end

    // A status match implies an in-range address, and a general match implies
    // wr_ok already vetted the address, so no extra range check is needed here.
    function automatic logic [WIDTH-1:0] read_mux(
        input logic [AW-1:0]    ra,
        input logic [WIDTH-1:0] stored,
        input logic             fwd,
        input logic             st_hit_en,
        input logic [WIDTH-1:0] st_d,
        input logic             wr_hit_en,
        input logic [AW-1:0]    wa,
        input logic [WIDTH-1:0] wd
    );
        logic [WIDTH-1:0] r;
        r = stored;
        if (fwd && st_hit_en && (ra == STATUS_A)) begin
            r = st_d;
        end else if (fwd && wr_hit_en && (wa == ra)) begin
            r = wd;
        end
        return r;
    endfunction

    always_comb begin
        rdata_a = read_mux(raddr_a, word_q[raddr_a], fwd_en, st_we, st_data, wr_ok, waddr, wdata);
        rdata_b = read_mux(raddr_b, word_q[raddr_b], fwd_en, st_we, st_data, wr_ok, waddr, wdata);
    end

endmodule

// File: tb/tb_regfile_bypass.sv
// Bench for regfile_bypass: three configurations driven in lockstep, checked
// every cycle against an array model plus hand-computed directed expectations.
module tb_regfile_bypass;

    logic        clk = 1'b0;
    logic        clr, we, st_we;
    logic [4:0]  waddr, raddr_a, raddr_b;
    logic [31:0] wdata, st_data;
    logic [31:0] a1, b1, a0, b0;
    logic [15:0] as, bs;

    int total = 0;
    int bad   = 0;
    bit run_cmp = 1'b0;

    always #5 clk = ~clk;

    regfile_bypass #(.BYPASS(1'b1)) dut_byp (
        .clk(clk), .clr(clr), .we(we), .waddr(waddr), .wdata(wdata),
        .st_we(st_we), .st_data(st_data),
        .raddr_a(raddr_a), .rdata_a(a1), .raddr_b(raddr_b), .rdata_b(b1)
    );

    regfile_bypass #(.BYPASS(1'b0)) dut_nobyp (
        .clk(clk), .clr(clr), .we(we), .waddr(waddr), .wdata(wdata),
        .st_we(st_we), .st_data(st_data),
        .raddr_a(raddr_a), .rdata_a(a0), .raddr_b(raddr_b), .rdata_b(b0)
    );

    regfile_bypass #(.WIDTH(16), .DEPTH(20), .STATUS_IDX(19), .BYPASS(1'b1)) dut_small (
        .clk(clk), .clr(clr), .we(we), .waddr(waddr), .wdata(wdata[15:0]),
        .st_we(st_we), .st_data(st_data[15:0]),
        .raddr_a(raddr_a), .rdata_a(as), .raddr_b(raddr_b), .rdata_b(bs)
    );

    // Model: configuration 0 = bypass, 1 = no bypass, 2 = 16x20 with status at 19.
    int          c_depth [3] = '{32, 32, 20};
    int          c_sidx  [3] = '{30, 30, 19};
    bit          c_byp   [3] = '{1'b1, 1'b0, 1'b1};
    logic [31:0] c_mask  [3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_FFFF};
    logic [31:0] mdl     [3][32];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_rd(input int c, input logic [4:0] ra);
        if (ra == 5'd0 || int'(ra) >= c_depth[c]) return 32'd0;
        if (c_byp[c] && !clr) begin
            if (st_we && int'(ra) == c_sidx[c]) return st_data & c_mask[c];
            if (we && waddr == ra) return wdata & c_mask[c];
        end
        return mdl[c][ra];
    endfunction

    function automatic logic [31:0] act_rd(input int c, input bit port_b);
        case (c)
            0:       return port_b ? b1 : a1;
            1:       return port_b ? b0 : a0;
            default: return port_b ? {16'd0, bs} : {16'd0, as};
        endcase
    endfunction

    always @(posedge clk) begin
        for (int c = 0; c < 3; c++) begin
            if (clr) begin
                for (int r = 0; r < 32; r++) mdl[c][r] <= 32'd0;
            end else begin
                if (we && waddr != 5'd0 && int'(waddr) < c_depth[c])
                    mdl[c][waddr] <= wdata & c_mask[c];
                if (st_we)
                    mdl[c][c_sidx[c]] <= st_data & c_mask[c];
            end
        end
    end

    always @(negedge clk) begin
        if (run_cmp) begin
            for (int c = 0; c < 3; c++) begin
                chk($sformatf("model_cfg%0d_a@%0d", c, raddr_a), act_rd(c, 1'b0), exp_rd(c, raddr_a));
                chk($sformatf("model_cfg%0d_b@%0d", c, raddr_b), act_rd(c, 1'b1), exp_rd(c, raddr_b));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        clr = 1'b1; we = 1'b0; st_we = 1'b0; waddr = '0; wdata = '0;
        st_data = '0; raddr_a = '0; raddr_b = '0;
        repeat (2) @(posedge clk);
        #1;
        clr = 1'b0;
        run_cmp = 1'b1;
        mid();
        chk("reset_a", a1, 32'd0);
        chk("reset_b", b1, 32'd0);
        tick();

        // Reset: r5 written, then cleared
        we = 1'b1; waddr = 5'd5; wdata = 32'hDEAD_BEEF; raddr_a = 5'd5; raddr_b = 5'd5;
        mid();
        chk("r5_bypass_same_cycle", a1, 32'hDEAD_BEEF);
        chk("r5_nobypass_old", a0, 32'd0);
        tick();
        we = 1'b0;
        mid();
        chk("r5_nobypass_next", a0, 32'hDEAD_BEEF);
        chk("r5_portb", b1, 32'hDEAD_BEEF);
        tick();
        clr = 1'b1; raddr_a = 5'd5; raddr_b = 5'd0;
        mid();
        chk("r5_during_clr", a1, 32'hDEAD_BEEF);
        tick();
        clr = 1'b0;
        mid();
        chk("r5_after_clr_a", a1, 32'd0);
        chk("r0_after_clr_b", b1, 32'd0);
        chk("r5_after_clr_nobyp", a0, 32'd0);
        tick();

        // Zero register
        we = 1'b1; waddr = 5'd0; wdata = 32'hFFFF_FFFF; raddr_a = 5'd0; raddr_b = 5'd0;
        mid();
        chk("r0_write_cycle_byp", a1, 32'd0);
        chk("r0_write_cycle_nobyp", a0, 32'd0);
        tick();
        we = 1'b0;
        mid();
        chk("r0_after_write_byp", a1, 32'd0);
        chk("r0_after_write_nobyp", b0, 32'd0);
        tick();

        // Bypass vs no bypass on r7
        we = 1'b1; waddr = 5'd7; wdata = 32'h1111; raddr_a = 5'd7;
        tick();
        wdata = 32'h1234;
        mid();
        chk("r7_byp_same_cycle", a1, 32'h1234);
        chk("r7_nobyp_old", a0, 32'h1111);
        tick();
        we = 1'b0;
        mid();
        chk("r7_byp_stored", a1, 32'h1234);
        chk("r7_nobyp_next", a0, 32'h1234);
        tick();

        // Collision on status index
        we = 1'b1; waddr = 5'd30; wdata = 32'hAAAA;
        st_we = 1'b1; st_data = 32'h5555; raddr_a = 5'd30; raddr_b = 5'd19;
        mid();
        chk("r30_collision_bypass", a1, 32'h5555);
        chk("r30_collision_nobyp_old", a0, 32'd0);
        chk("small_r19_status_bypass", {16'd0, bs}, 32'h5555);
        chk("small_r30_out_of_range", {16'd0, as}, 32'd0);
        tick();
        we = 1'b0; st_we = 1'b0;
        mid();
        chk("r30_after_collision_byp", a1, 32'h5555);
        chk("r30_after_collision_nobyp", a0, 32'h5555);
        chk("small_r19_stored", {16'd0, bs}, 32'h5555);
        tick();

        // Clear priority over write
        we = 1'b1; waddr = 5'd3; wdata = 32'h42; raddr_a = 5'd3; raddr_b = 5'd3;
        tick();
        clr = 1'b1; wdata = 32'h99;
        mid();
        chk("r3_clr_no_bypass", a1, 32'h42);
        chk("r3_clr_nobyp", b0, 32'h42);
        tick();
        clr = 1'b0; we = 1'b0;
        mid();
        chk("r3_after_clr", a1, 32'd0);
        tick();

        // Small config: out-of-range write is ignored
        we = 1'b1; waddr = 5'd25; wdata = 32'hBEEF; raddr_a = 5'd25; raddr_b = 5'd25;
        mid();
        chk("small_r25_write_cycle", {16'd0, as}, 32'd0);
        tick();
        waddr = 5'd20; wdata = 32'h0001;
        tick();
        we = 1'b0;
        for (int i = 0; i < 32; i++) begin
            raddr_a = 5'(i);
            mid();
            chk($sformatf("small_scan_r%0d", i), {16'd0, as}, 32'd0);
            tick();
        end

        // Small config: status write reaches r19; upper data bits dropped
        st_we = 1'b1; st_data = 32'hABCD_7777; raddr_b = 5'd19;
        mid();
        chk("small_r19_status_same", {16'd0, bs}, 32'h7777);
        tick();
        st_we = 1'b0;
        mid();
        chk("small_r19_status_next", {16'd0, bs}, 32'h7777);
        chk("big_r19_untouched", b1, 32'd0);
        tick();

        // Last legal index and both ports on one address
        we = 1'b1; waddr = 5'd31; wdata = 32'hC0FF_EE00; raddr_a = 5'd31; raddr_b = 5'd31;
        mid();
        chk("r31_both_ports_a", a1, 32'hC0FF_EE00);
        chk("r31_both_ports_b", b1, 32'hC0FF_EE00);
        tick();
        waddr = 5'd19; wdata = 32'h0000_0BAD; raddr_a = 5'd19; raddr_b = 5'd31;
        mid();
        chk("small_r19_general_byp", {16'd0, as}, 32'h0BAD);
        chk("r31_nobyp_stored", b0, 32'hC0FF_EE00);
        tick();
        we = 1'b0;
        mid();
        chk("small_r19_general_stored", {16'd0, as}, 32'h0BAD);
        tick();

        // A few mixed writes for the model to chase
        for (int k = 1; k < 12; k++) begin
            we = 1'b1; waddr = 5'(k * 3 % 32); wdata = 32'h1000_0000 + 32'(k * 17);
            st_we = (k % 4 == 0); st_data = 32'h2000_0000 + 32'(k);
            raddr_a = 5'(k * 3 % 32); raddr_b = 5'((k * 3 + 29) % 32);
            tick();
        end
        we = 1'b0; st_we = 1'b0;
        tick();

        run_cmp = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/regfile_bypass.md
# regfile_bypass

Parametrised register file with two combinational read ports and one general write port. A dedicated status write port updates a fixed status register, and optional write-to-read bypass is available. Register 0 is hard-wired to zero. It is the processor's architectural register file: decode reads it, and writeback plus exception logic write it. It generalises the fixed 32-bit enable-register to DEPTH words of WIDTH bits.

## Interface
- WIDTH, 32, data width of every register
- DEPTH, 32, number of registers (≥ 2, any value)
- AW, $clog2(DEPTH), address width (derived, not overridden)
- STATUS_IDX, 30, index written by the status port (1 ≤ STATUS_IDX < DEPTH)
- BYPASS, 1, 1 = same-cycle write data forwarded to reads; 0 = reads return stored value only

- clk  in  1  single clock, all state updates on rising edge
- clr  in  1  reset, synchronous, active-high
- we  in  1  general write enable
- waddr  in  AW  general write address
- wdata  in  WIDTH  general write data
- st_we  in  1  status write enable
- st_data  in  WIDTH  status write data, targets STATUS_IDX
- raddr_a  in  AW  read port A address
- rdata_a  out  WIDTH  read port A data, combinational
- raddr_b  in  AW  read port B address
- rdata_b  out  WIDTH  read port B data, combinational

## Operation
- **Storage:** registers 1..DEPTH-1 are WIDTH-bit state. Register 0 has no storage and always reads 0.
- **General write:** at the clock edge, when we=1, waddr≠0 and waddr<DEPTH, reg[waddr] ← wdata. Otherwise nothing changes.
- **Status write:** at the clock edge, when st_we=1, reg[STATUS_IDX] ← st_data.
- **Write collision:** if both ports target STATUS_IDX in the same cycle, the status port wins and wdata is discarded. Writes to different indices both commit.
- **Clear:**
  - clr=1 zeroes every register at the edge.
  - clr has priority over both write ports; writes in that cycle are dropped.
- **Read:** rdata_x = 0 if raddr_x=0 or raddr_x≥DEPTH; otherwise the selected value below.
- **Bypass (BYPASS=1, clr=0), priority order:**
  - st_we and raddr_x=STATUS_IDX → st_data
  - else we, waddr=raddr_x, waddr≠0 → wdata
  - else stored value
- **Bypass suppression:** bypass is disabled when clr=1, so reads return stored values.
- **BYPASS=0:** reads always return the stored value. A write becomes visible in the cycle after its edge.
- **Independence:** both read ports are fully independent and may use the same address.

## Timing
- Reset value: every register 0, so every rdata is 0 after a clr edge with no write in flight.
- Write latency: 1 edge to storage.
- Read latency:
  - BYPASS=1: 0 cycles, same-cycle write visible.
  - BYPASS=0: 1 cycle.
- Read path is purely combinational from addresses, storage, and write-port inputs. No output registers.
- clr asserted mid-stream: the value present at that edge is lost. The first write after deassertion commits on the following edge.
- No handshake; every write is accepted in the cycle it is presented, subject to the ignore rules above.

## Structure
- The shared processor package holds:
  - default WIDTH/DEPTH
  - STATUS_IDX (30)
  - the zero-register index constant
- One sub-module, reg_word: WIDTH-parameterised register with enable and synchronous clr. It is instantiated DEPTH-1 times via generate, each with enable = decoded write select.
- Write decode, collision priority, and bypass muxing live in regfile_bypass itself.

## Test plan
- **Reset:**
  - Stimulus: write 0xDEADBEEF to r5, pulse clr for 1 cycle, read r5 on A and r0 on B.
  - Required: rdata_a=0 and rdata_b=0.
- **Zero register:**
  - Stimulus: we=1, waddr=0, wdata=0xFFFFFFFF, then read r0.
  - Required: rdata=0 both during the write cycle and after it.
- **Bypass:**
  - Stimulus: BYPASS=1; in one cycle we=1, waddr=7, wdata=0x1234, raddr_a=7.
  - Required: rdata_a=0x1234 in the same cycle, and r7 holds 0x1234 afterwards.
  - Stimulus: the same sequence with BYPASS=0.
  - Required: old value in the write cycle, 0x1234 in the next cycle.
- **Collision:**
  - Stimulus: we=1, waddr=30, wdata=0xAAAA and st_we=1, st_data=0x5555 in the same cycle.
  - Required: reg[30]=0x5555, and the bypassed read of r30 shows 0x5555.
- **Clear priority:**
  - Stimulus: clr=1 together with we=1, waddr=3, wdata=0x99.
  - Required: r3=0 after the edge, and rdata shows the stored value during that cycle (no bypass).
- **Parametrisation:**
  - Stimulus: WIDTH=16, DEPTH=20, STATUS_IDX=19; write to address 25; read address 25.
  - Required: no register changes and the read returns 0.
  - Stimulus: a status write.
  - Required: r19 is updated.
